// File: rtl/xbar_phase_xactor.sv
// Crossbar phase transactor: queues full packets, plays headers then payloads on
// crossbar phase strobes, and reassembles the looped-back words into result packets.
module xbar_phase_xactor #(
  parameter int PORTS = 4,
  parameter int PKT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PORTS*2*PKT_W-1:0]     in_data,
  input  logic                         phase_stb,
  input  logic                         header_present,
  output logic [PORTS*PKT_W-1:0]       dut_data,
  input  logic [PORTS*PKT_W-1:0]       res_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PORTS*2*PKT_W-1:0]     out_data,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic [15:0]                  ovf_cnt
);
  localparam int PW = PORTS*2*PKT_W;
  localparam int WW = PORTS*PKT_W;
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] cur_q, cur_d;
  logic [WW-1:0] dut_data_q, dut_data_d;
  logic [WW-1:0] rx_hdr_q, rx_hdr_d, rx_pay_q, rx_pay_d;
  logic          out_valid_q, out_valid_d;
  logic [PW-1:0] out_data_q, out_data_d;
  logic [15:0]   ovf_q, ovf_d;
  logic          push, pop, leave_hdr, leave_pay, fifo_empty;
  logic [WW-1:0] cur_hdr, cur_pay;
  logic [PW-1:0] result;

  assign in_ready   = (count_q < DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign push       = in_valid && in_ready;

  // Per-port split of the packet entering the transmitter and merge of the returned words.
  for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
    assign cur_hdr[gi*PKT_W +: PKT_W]     = cur_d[gi*2*PKT_W + PKT_W +: PKT_W];
    assign cur_pay[gi*PKT_W +: PKT_W]     = cur_d[gi*2*PKT_W +: PKT_W];
    assign result[gi*2*PKT_W +: 2*PKT_W]  = {rx_hdr_q[gi*PKT_W +: PKT_W], rx_pay_d[gi*PKT_W +: PKT_W]};
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cur_q       <= '0;
      dut_data_q  <= '0;
      rx_hdr_q    <= '0;
      rx_pay_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cur_q       <= cur_d;
      dut_data_q  <= dut_data_d;
      rx_hdr_q    <= rx_hdr_d;
      rx_pay_q    <= rx_pay_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    leave_hdr = 1'b0;
    leave_pay = 1'b0;
    if (phase_stb) begin
      case (state_q)
        IDLE: if (header_present && !fifo_empty) begin
          state_d = HDR;
          pop     = 1'b1;
        end
        HDR: if (!header_present) begin
          state_d   = PAY;
          leave_hdr = 1'b1;
        end
        PAY: if (header_present) begin
          leave_pay = 1'b1;
          if (!fifo_empty) begin
            state_d = HDR;
            pop     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    cur_d       = cur_q;
    rx_hdr_d    = rx_hdr_q;
    rx_pay_d    = rx_pay_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ovf_d       = ovf_q;
    dut_data_d  = '0;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      cur_d    = mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (leave_hdr) rx_hdr_d = res_data;
    if (leave_pay) rx_pay_d = res_data;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    // A completion that finds the output slot still occupied is dropped and counted.
    if (leave_pay) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_data_d  = result;
      end else if (ovf_q != 16'hFFFF) begin
        ovf_d = ovf_q + 16'd1;
      end
    end
    case (state_d)
      HDR:     dut_data_d = cur_hdr;
      PAY:     dut_data_d = cur_pay;
      default: dut_data_d = '0;
    endcase
  end

  assign dut_data   = dut_data_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign fifo_level = count_q;
  assign ovf_cnt    = ovf_q;
endmodule
